instr_fetch_decode: RTL

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

---
 rtl/instr_fetch_decode_pkg.sv | 33 +++
 rtl/instr_decoder.sv | 55 +++++
 rtl/instr_fetch_decode.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_decode_pkg
// Brief   : Opcodes, FSM encoding and instruction field positions shared by
//           the fetch/decode block and its decoder.
// Revision: 1.0
// ============================================================================
package instr_fetch_decode_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 2;
    localparam int RD_HI  = 1;
    localparam int RD_LO  = 0;
    localparam int IMM_HI = 1;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module  : instr_decoder
// Brief   : Combinational field split, immediate sign-extension and control
//           strobe generation for one instruction byte.
// Revision: 1.0
// ============================================================================
module instr_decoder
    import instr_fetch_decode_pkg::*;
(
    input  logic [7:0] i_instruction,
    output logic [1:0] o_op,
    output logic [1:0] o_rs,
    output logic [1:0] o_rt,
    output logic [1:0] o_rd,
    output logic [7:0] o_imm_ext,
    output logic       o_reg_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_mem_to_reg,
    output logic       o_alu_src,
    output logic       o_is_jump
);

    assign o_op      = i_instruction[OP_HI:OP_LO];
    assign o_rs      = i_instruction[RS_HI:RS_LO];
    assign o_rt      = i_instruction[RT_HI:RT_LO];
    assign o_rd      = i_instruction[RD_HI:RD_LO];
    assign o_imm_ext = {{6{i_instruction[IMM_HI]}}, i_instruction[IMM_HI:IMM_LO]};

    always_comb begin
        o_reg_write  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_src    = 1'b0;
        o_is_jump    = 1'b0;
        case (o_op)
            OP_ADD: o_reg_write = 1'b1;
            OP_LW: begin
                o_reg_write  = 1'b1;
                o_mem_read   = 1'b1;
                o_mem_to_reg = 1'b1;
                o_alu_src    = 1'b1;
            end
            OP_SW: begin
                o_mem_write = 1'b1;
                o_alu_src   = 1'b1;
            end
            default: o_is_jump = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_decode
// Brief   : PC, FIRST/RUN/HALTED control and the decode pipeline register
//           stage in front of a combinational instruction memory.
// Revision: 1.0
// ============================================================================
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter logic [7:0] RESET_PC          = 8'h00,
    parameter bit         HALT_ON_SELF_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [7:0] instruction,
    output logic [7:0] read_address,
    output logic [7:0] dec_pc,
    output logic [1:0] op,
    output logic [1:0] rs,
    output logic [1:0] rt,
    output logic [1:0] rd,
    output logic [7:0] imm_ext,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       is_jump,
    output logic       dec_valid,
    output logic       halted
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_pc;
    logic [7:0] w_pc_next;
    logic       w_fetch;
    logic       w_self_jump;

    logic [1:0] w_op, w_rs, w_rt, w_rd;
    logic [7:0] w_imm;
    logic       w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg, w_alu_src, w_is_jump;

    instr_decoder u_decoder (
        .i_instruction (instruction),
        .o_op          (w_op),
        .o_rs          (w_rs),
        .o_rt          (w_rt),
        .o_rd          (w_rd),
        .o_imm_ext     (w_imm),
        .o_reg_write   (w_reg_write),
        .o_mem_read    (w_mem_read),
        .o_mem_write   (w_mem_write),
        .o_mem_to_reg  (w_mem_to_reg),
        .o_alu_src     (w_alu_src),
        .o_is_jump     (w_is_jump)
    );

    // imm of -1 makes the jump target equal to the jump's own address
    assign w_self_jump = (w_op == OP_J) && (instruction[IMM_HI:IMM_LO] == 2'b11);

    always_comb begin
        w_state_next = r_state;
        w_fetch      = 1'b0;
        w_pc_next    = r_pc;
        case (r_state)
            ST_FIRST: begin
                if (!stall) begin
                    w_fetch      = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    w_fetch = 1'b1;
                    if (HALT_ON_SELF_JUMP && w_self_jump)
                        w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_FIRST;
        endcase
        if (w_fetch)
            w_pc_next = (w_op == OP_J) ? (r_pc + 8'd1 + w_imm) : (r_pc + 8'd1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_FIRST;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            dec_valid  <= 1'b0;
            dec_pc     <= 8'h00;
            op         <= 2'b00;
            rs         <= 2'b00;
            rt         <= 2'b00;
            rd         <= 2'b00;
            imm_ext    <= 8'h00;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_src    <= 1'b0;
            is_jump    <= 1'b0;
        end else begin
            r_pc      <= w_pc_next;
            dec_valid <= w_fetch;
            if (w_fetch) begin
                dec_pc     <= r_pc;
                op         <= w_op;
                rs         <= w_rs;
                rt         <= w_rt;
                rd         <= w_rd;
                imm_ext    <= w_imm;
                reg_write  <= w_reg_write;
                mem_read   <= w_mem_read;
                mem_write  <= w_mem_write;
                mem_to_reg <= w_mem_to_reg;
                alu_src    <= w_alu_src;
                is_jump    <= w_is_jump;
            end
        end
    end

    assign read_address = r_pc;
    assign halted       = (r_state == ST_HALTED);

endmodule
`default_nettype wire
